mem_access: RTL

Load/store unit sitting between the EX stage and `data_ram`. It accepts one memory request at a time from EX using a valid/ready handshake, and converts byte addresses to word indices. Sub-word stores are done as a read-modify-write, because `data_ram` only has a whole-word write enable. Load data is sign- or zero-extended and returned to WB with a one-cycle valid pulse.

---
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// mem_access_if: EX request, data_ram and WB return signals of the load/store unit.
// slave = the unit itself; master = the EX/RAM/WB side driving it.
interface mem_access_if;
    logic        ex2mem_req;
    logic        mem2ex_ready;
    logic        ex2mem_we;
    logic [31:0] ex2mem_addr;
    logic [31:0] ex2mem_wdata;
    logic [1:0]  ex2mem_size;
    logic        ex2mem_unsigned;
    logic        mem2ram_we;
    logic [31:0] mem2ram_addr;
    logic [31:0] mem2ram_data;
    logic [31:0] ram2mem_data;
    logic        mem2wb_valid;
    logic [31:0] mem2wb_rdata;
    logic        mem2wb_misalign;

    modport slave (
        input  ex2mem_req, ex2mem_we, ex2mem_addr, ex2mem_wdata,
        input  ex2mem_size, ex2mem_unsigned, ram2mem_data,
        output mem2ex_ready, mem2ram_we, mem2ram_addr, mem2ram_data,
        output mem2wb_valid, mem2wb_rdata, mem2wb_misalign
    );

    modport master (
        output ex2mem_req, ex2mem_we, ex2mem_addr, ex2mem_wdata,
        output ex2mem_size, ex2mem_unsigned, ram2mem_data,
        input  mem2ex_ready, mem2ram_we, mem2ram_addr, mem2ram_data,
        input  mem2wb_valid, mem2wb_rdata, mem2wb_misalign
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: load/store unit between EX and data_ram; sub-word stores use read-modify-write.
// Ports: clk, rst (async, active-high), bus (mem_access_if.slave).
// Option: LSU_MISALIGN_TRAP_EN drops misaligned half/word accesses and flags them to WB.
module mem_access #(
    parameter int RAM_DEPTH_LOG2 = 12
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    logic [31:0] widx;
    logic [1:0]  aoff;
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] ext;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [31:0] merged;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^bus.ex2mem_addr[31:RAM_DEPTH_LOG2+2];

    // Upper address bits are dropped so accesses wrap over the RAM.
    assign widx = {{(32-RAM_DEPTH_LOG2){1'b0}},
                   bus.ex2mem_addr[RAM_DEPTH_LOG2+1:2]};

    // Misaligned low bits are forced to 0 for half and word sizes.
    always_comb begin
        aoff = bus.ex2mem_addr[1:0];
        if (bus.ex2mem_size[1])
            aoff = 2'b00;
        else if (bus.ex2mem_size[0])
            aoff[0] = 1'b0;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    assign misal = (bus.ex2mem_size == 2'b01 && bus.ex2mem_addr[0]) ||
                   (bus.ex2mem_size[1] && bus.ex2mem_addr[1:0] != 2'b00);
`endif

    assign sh   = {off_q, 3'b000};
    assign lane = bus.ram2mem_data >> sh;

    always_comb begin
        if (size_q[1])
            ext = lane;
        else if (size_q[0])
            ext = {{16{lane[15] & ~uns_q}}, lane[15:0]};
        else
            ext = {{24{lane[7] & ~uns_q}}, lane[7:0]};
    end

    assign mask   = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    assign ins    = {16'h0000, wdata_q} << sh;
    assign merged = (bus.ram2mem_data & ~mask) | (ins & mask);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        we_d    = 1'b0;
        data_d  = data_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ex2mem_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misal) begin
                        valid_d = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else
`endif
                    begin
                        addr_d  = widx;
                        wdata_d = bus.ex2mem_wdata[15:0];
                        size_d  = bus.ex2mem_size;
                        uns_d   = bus.ex2mem_unsigned;
                        off_d   = aoff;
                        if (!bus.ex2mem_we) begin
                            state_d = LOAD;
                        end else if (bus.ex2mem_size[1]) begin
                            state_d = WRITE;
                            we_d    = 1'b1;
                            data_d  = bus.ex2mem_wdata;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            LOAD: begin
                rdata_d = ext;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            RMW_RD: begin
                data_d  = merged;
                we_d    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                rdata_d = 32'h0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 16'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            we_q    <= we_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.mem2ex_ready    = (state_q == IDLE);
    assign bus.mem2ram_we      = we_q;
    assign bus.mem2ram_addr    = addr_q;
    assign bus.mem2ram_data    = data_q;
    assign bus.mem2wb_valid    = valid_q;
    assign bus.mem2wb_rdata    = rdata_q;
    assign bus.mem2wb_misalign = mis_q;

endmodule
